// File: rtl/spi_bus_arbiter_pkg.sv
// Shared constants and types for the SPI bus arbiter and its users.
package spi_bus_arbiter_pkg;

  // Datapath register width of the attached functional units.
  localparam int REGISTER_SIZE = 16;

  // Small opcode field carried in the low nibble of an operation packet.
  localparam int OP_BITS = 4;
  localparam logic [OP_BITS-1:0] OP_ADD = 4'h1;
  localparam logic [OP_BITS-1:0] OP_SUB = 4'h2;
  localparam logic [OP_BITS-1:0] OP_SHL = 4'h3;
  localparam logic [OP_BITS-1:0] OP_MUL = 4'h4;

  // Result width returned by every slave.
  localparam int RX_BITS = REGISTER_SIZE;

  // Default outgoing packet widths: {operand_a, operand_b, op} and variants.
  localparam int ALU_TX_BITS   = 2 * REGISTER_SIZE + OP_BITS;  // 36
  localparam int SHIFT_TX_BITS = REGISTER_SIZE + 4 + OP_BITS;  // operand, shift amount, op
  localparam int MUL_TX_BITS   = 2 * REGISTER_SIZE;            // two operands, fixed op

  // Arbiter transaction state, one-hot.
  typedef enum logic [5:0] {
    ST_IDLE      = 6'b000001,
    ST_START     = 6'b000010,
    ST_SHIFT_OUT = 6'b000100,
    ST_WAIT_RESP = 6'b001000,
    ST_SHIFT_IN  = 6'b010000,
    ST_DONE      = 6'b100000
  } arb_state_e;

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Requester handshake and SPI bus signals of the arbiter, bundled.
//
// Handshake: a requester raises i_req[r] (level) with i_slave/i_tx_len/i_tx_data
// stable; the arbiter latches those fields when it selects r, raises o_grant[r]
// while the transaction runs, and pulses o_done[r] for exactly one cycle with
// o_error and o_rx_data valid in that same cycle. i_req may drop at any point
// after selection without affecting the transaction.
interface spi_bus_arbiter_if #(
  parameter int NumRequesters = 2,
  parameter int NumSlaves     = 3,
  parameter int MaxTxBits     = 36,
  parameter int RxBits        = 16
);
  import spi_bus_arbiter_pkg::*;

  localparam int SlvW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
  localparam int LenW = $clog2(MaxTxBits + 1);

  logic [NumRequesters-1:0]                i_req;
  logic [NumRequesters-1:0][SlvW-1:0]      i_slave;
  logic [NumRequesters-1:0][LenW-1:0]      i_tx_len;
  logic [NumRequesters-1:0][MaxTxBits-1:0] i_tx_data;
  logic [NumRequesters-1:0]                o_grant;
  logic [NumRequesters-1:0]                o_done;
  logic                                    o_error;
  logic [RxBits-1:0]                       o_rx_data;
  logic                                    o_sclk;
  logic [NumSlaves-1:0]                    o_nss;
  logic                                    o_mosi;
  logic                                    i_miso;
  arb_state_e                              dbg_state;

  // Arbiter side: drives the SPI bus as master and answers the requesters.
  modport master (
    input  i_req, i_slave, i_tx_len, i_tx_data, i_miso,
    output o_grant, o_done, o_error, o_rx_data, o_sclk, o_nss, o_mosi, dbg_state
  );

  // Environment side: requesters plus the SPI slaves.
  modport slave (
    output i_req, i_slave, i_tx_len, i_tx_data, i_miso,
    input  o_grant, o_done, o_error, o_rx_data, o_sclk, o_nss, o_mosi, dbg_state
  );

endinterface

// File: rtl/spi_bus_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or above the pointer, with wrap.
module spi_rr_picker #(
  parameter int N    = 2,
  parameter int IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] winner_o,
  output logic            valid_o
);

  logic [IdxW-1:0] idx;

  // Scan in reverse priority order so the highest-priority hit is written last.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IdxW'((int'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus among several requesters; frames one transaction at a time.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NumRequesters = 2,
  parameter int NumSlaves     = 3,
  parameter int MaxTxBits     = ALU_TX_BITS,
  parameter int RxBits        = RX_BITS,
  parameter int TimeoutCycles = 255
) (
  input  logic               i_clock,
  input  logic               i_reset,
  spi_bus_arbiter_if.master  bus
);

  localparam int IdxW    = $clog2(NumRequesters);
  localparam int SlvW    = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
  localparam int LenW    = $clog2(MaxTxBits + 1);
  localparam int CntMax  = (MaxTxBits > RxBits) ? MaxTxBits : RxBits;
  localparam int CntW    = $clog2(CntMax + 1);
  localparam int TxIdxW  = $clog2(MaxTxBits);
  localparam int RxIdxW  = $clog2(RxBits);
  localparam int WdW     = $clog2(TimeoutCycles + 1);

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       rr_q, rr_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [SlvW-1:0]       slave_q, slave_d;
  logic [LenW-1:0]       len_q, len_d;
  logic [MaxTxBits-1:0]  tx_q, tx_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WdW-1:0]        wd_q, wd_d;
  logic [RxBits-1:0]     rx_shift_q, rx_shift_d;
  logic [RxBits-1:0]     rx_data_q, rx_data_d;
  logic                  err_q, err_d;

  logic [IdxW-1:0]       pick_idx;
  logic                  pick_valid;
  logic                  pick_bad;
  logic                  bus_active;

  spi_rr_picker #(.N(NumRequesters), .IdxW(IdxW)) u_picker (
    .req_i    (bus.i_req),
    .ptr_i    (rr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  // A request is unusable if it names a missing slave or an out-of-range length.
  always_comb begin
    pick_bad = (32'(bus.i_slave[pick_idx]) >= NumSlaves) ||
               (bus.i_tx_len[pick_idx] == '0) ||
               (32'(bus.i_tx_len[pick_idx]) > MaxTxBits);
  end

  // State and datapath registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      owner_q    <= '0;
      slave_q    <= '0;
      len_q      <= '0;
      tx_q       <= '0;
      bit_cnt_q  <= '0;
      wd_q       <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      slave_q    <= slave_d;
      len_q      <= len_d;
      tx_q       <= tx_d;
      bit_cnt_q  <= bit_cnt_d;
      wd_q       <= wd_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: arbitration, framing, watchdog and result capture.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    slave_d    = slave_q;
    len_d      = len_q;
    tx_d       = tx_q;
    bit_cnt_d  = bit_cnt_q;
    wd_d       = wd_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d   = pick_idx;
          slave_d   = bus.i_slave[pick_idx];
          len_d     = bus.i_tx_len[pick_idx];
          tx_d      = bus.i_tx_data[pick_idx];
          bit_cnt_d = '0;
          wd_d      = '0;
          err_d     = pick_bad;
          state_d   = pick_bad ? ST_DONE : ST_START;
        end
      end
      ST_START: begin
        // A high miso means another master or slave still holds the line.
        if (!bus.i_miso) begin
          bit_cnt_d = '0;
          state_d   = ST_SHIFT_OUT;
        end
      end
      ST_SHIFT_OUT: begin
        if (bit_cnt_q + CntW'(1) == CntW'(len_q)) begin
          bit_cnt_d = '0;
          wd_d      = '0;
          state_d   = ST_WAIT_RESP;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      ST_WAIT_RESP: begin
        if (bus.i_miso) begin
          bit_cnt_d = '0;
          state_d   = ST_SHIFT_IN;
        end else if (wd_q == WdW'(TimeoutCycles - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      ST_SHIFT_IN: begin
        rx_shift_d[bit_cnt_q[RxIdxW-1:0]] = bus.i_miso;
        if (bit_cnt_q == CntW'(RxBits - 1)) begin
          // Publish on entry to DONE so the result is valid alongside o_done.
          rx_data_d = rx_shift_d;
          state_d   = ST_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      ST_DONE: begin
        rr_d    = (32'(owner_q) == NumRequesters - 1) ? '0 : owner_q + IdxW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    bus_active    = (state_q == ST_START) || (state_q == ST_SHIFT_OUT) ||
                    (state_q == ST_WAIT_RESP) || (state_q == ST_SHIFT_IN);
    bus.o_grant   = '0;
    bus.o_done    = '0;
    bus.o_nss     = '1;
    bus.o_mosi    = 1'b0;
    bus.o_error   = 1'b0;
    if (bus_active) begin
      bus.o_grant[owner_q] = 1'b1;
      bus.o_nss[slave_q]   = 1'b0;
    end
    if (state_q == ST_START) begin
      bus.o_mosi = 1'b1;
    end else if (state_q == ST_SHIFT_OUT) begin
      bus.o_mosi = tx_q[bit_cnt_q[TxIdxW-1:0]];
    end
    if (state_q == ST_DONE) begin
      bus.o_done[owner_q] = 1'b1;
      bus.o_error         = err_q;
    end
  end

  assign bus.o_rx_data = rx_data_q;
  assign bus.o_sclk    = i_clock;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a behavioural SPI slave.
module tb_spi_bus_arbiter;
  import spi_bus_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_bus_arbiter_if bus ();

  spi_bus_arbiter dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- slave model ----------------
  bit          slv_respond = 1'b1;
  int          slv_busy    = 0;
  int          slv_delay   = 2;
  int          slv_len     = 36;
  logic [15:0] slv_resp    = '0;
  logic [35:0] cap         = '0;

  initial begin
    bus.i_miso = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_nss != 3'b111) begin
        for (int b = 0; b < slv_busy; b++) begin
          bus.i_miso = 1'b1;
          @(negedge clk);
        end
        bus.i_miso = 1'b0;
        @(negedge clk);
        for (int i = 0; i < slv_len; i++) begin
          cap[i] = bus.o_mosi;
          @(negedge clk);
        end
        if (slv_respond) begin
          repeat (slv_delay) @(negedge clk);
          bus.i_miso = 1'b1;
          @(negedge clk);
          for (int i = 0; i < 16; i++) begin
            bus.i_miso = slv_resp[i];
            @(negedge clk);
          end
          bus.i_miso = 1'b0;
        end
        while (bus.o_nss != 3'b111) @(negedge clk);
      end
    end
  end

  // Counts cycles where more than one grant bit is set.
  int grant_multi = 0;
  always @(negedge clk) begin
    if (!$onehot0(bus.o_grant)) grant_multi++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int r, input logic [1:0] slv, input logic [5:0] len,
                         input logic [35:0] data);
    bus.i_slave[r]   = slv;
    bus.i_tx_len[r]  = len;
    bus.i_tx_data[r] = data;
    bus.i_req[r]     = 1'b1;
  endtask

  // Called just after the sampling edge; cycle 1 is the first cycle after it.
  task automatic wait_done(input int budget, output int cyc, output logic [1:0] who,
                           output logic err, output logic [15:0] rx,
                           output logic [2:0] nss1, output logic mosi1,
                           output logic [1:0] grant1, output bit nss_low);
    cyc = -1; who = '0; err = 1'b0; rx = '0;
    nss1 = '0; mosi1 = 1'b0; grant1 = '0; nss_low = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) begin
        nss1 = bus.o_nss; mosi1 = bus.o_mosi; grant1 = bus.o_grant;
      end
      if (bus.o_nss != 3'b111) nss_low = 1'b1;
      if (bus.o_done != '0) begin
        cyc = c; who = bus.o_done; err = bus.o_error; rx = bus.o_rx_data;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_req = '0; bus.i_slave = '0; bus.i_tx_len = '0; bus.i_tx_data = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got=%b exp=00", bus.o_grant); end
    n_tests++; if (bus.o_done !== 2'b00) begin n_fail++; $display("FAIL reset_done got=%b exp=00", bus.o_done); end
    n_tests++; if (bus.o_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", bus.o_error); end
    n_tests++; if (bus.o_rx_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rx got=%h exp=0000", bus.o_rx_data); end
    n_tests++; if (bus.o_nss !== 3'b111) begin n_fail++; $display("FAIL reset_nss got=%b exp=111", bus.o_nss); end
    n_tests++; if (bus.o_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", bus.o_mosi); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_alu();
    int cyc; logic [1:0] who, g1; logic err, m1; logic [15:0] rx; logic [2:0] n1; bit nl;
    logic [35:0] data;
    data = {16'h0005, 16'h0003, 4'h1};
    slv_respond = 1'b1; slv_busy = 0; slv_delay = 2; slv_len = 36; slv_resp = 16'h0008;
    set_req(0, 2'd0, 6'd36, data);
    @(posedge clk);
    wait_done(200, cyc, who, err, rx, n1, m1, g1, nl);
    bus.i_req[0] = 1'b0;
    n_tests++; if (cyc !== 57) begin n_fail++; $display("FAIL alu_done_cycle got=%0d exp=57", cyc); end
    n_tests++; if (who !== 2'b01) begin n_fail++; $display("FAIL alu_done_who got=%b exp=01", who); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL alu_error got=%b exp=0", err); end
    n_tests++; if (rx !== 16'h0008) begin n_fail++; $display("FAIL alu_rx got=%h exp=0008", rx); end
    n_tests++; if (cap !== data) begin n_fail++; $display("FAIL alu_mosi_bits got=%h exp=%h", cap, data); end
    n_tests++; if (n1 !== 3'b110) begin n_fail++; $display("FAIL alu_start_nss got=%b exp=110", n1); end
    n_tests++; if (m1 !== 1'b1) begin n_fail++; $display("FAIL alu_start_mosi got=%b exp=1", m1); end
    n_tests++; if (g1 !== 2'b01) begin n_fail++; $display("FAIL alu_grant got=%b exp=01", g1); end
    n_tests++; if (bus.o_nss !== 3'b111) begin n_fail++; $display("FAIL alu_done_nss got=%b exp=111", bus.o_nss); end
    n_tests++; if (bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL alu_done_grant got=%b exp=00", bus.o_grant); end
    @(negedge clk);
    n_tests++; if (bus.o_done !== 2'b00) begin n_fail++; $display("FAIL alu_done_pulse got=%b exp=00", bus.o_done); end
  endtask

  task automatic test_busy_bus();
    int cyc; logic [1:0] who, g1; logic err, m1; logic [15:0] rx; logic [2:0] n1; bit nl;
    slv_respond = 1'b1; slv_busy = 4; slv_delay = 2; slv_len = 8; slv_resp = 16'h1234;
    set_req(0, 2'd2, 6'd8, 36'hA5);
    @(posedge clk);
    wait_done(200, cyc, who, err, rx, n1, m1, g1, nl);
    bus.i_req[0] = 1'b0;
    slv_busy = 0;
    n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL busy_done_cycle got=%0d exp=33", cyc); end
    n_tests++; if (n1 !== 3'b011) begin n_fail++; $display("FAIL busy_nss got=%b exp=011", n1); end
    n_tests++; if (cap[7:0] !== 8'hA5) begin n_fail++; $display("FAIL busy_mosi_bits got=%h exp=a5", cap[7:0]); end
    n_tests++; if (rx !== 16'h1234 || err !== 1'b0) begin n_fail++; $display("FAIL busy_result got=%h/%b exp=1234/0", rx, err); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int cyc; logic [1:0] who, g1; logic err, m1; logic [15:0] rx; logic [2:0] n1; bit nl;
    logic [1:0] exp_who[4];
    int         exp_cyc[4];
    exp_who = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_cyc = '{25, 26, 26, 26};
    do_reset();
    slv_respond = 1'b1; slv_busy = 0; slv_delay = 2; slv_len = 4; slv_resp = 16'hC3C3;
    set_req(0, 2'd0, 6'd4, 36'h9);
    set_req(1, 2'd1, 6'd4, 36'h6);
    @(posedge clk);
    for (int t = 0; t < 4; t++) begin
      wait_done(100, cyc, who, err, rx, n1, m1, g1, nl);
      if (t == 0) begin
        n_tests++; if (g1 !== 2'b01) begin n_fail++; $display("FAIL cont_first_grant got=%b exp=01", g1); end
      end
      n_tests++; if (who !== exp_who[t]) begin n_fail++; $display("FAIL cont_order_%0d got=%b exp=%b", t, who, exp_who[t]); end
      n_tests++; if (cyc !== exp_cyc[t]) begin n_fail++; $display("FAIL cont_cycle_%0d got=%0d exp=%0d", t, cyc, exp_cyc[t]); end
    end
    bus.i_req = '0;
    n_tests++; if (cap[3:0] !== 4'h6) begin n_fail++; $display("FAIL cont_mosi_req1 got=%h exp=6", cap[3:0]); end
    n_tests++; if (rx !== 16'hC3C3) begin n_fail++; $display("FAIL cont_rx got=%h exp=c3c3", rx); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc; logic [1:0] who, g1; logic err, m1; logic [15:0] rx; logic [2:0] n1; bit nl;
    slv_respond = 1'b0; slv_len = 4;
    set_req(0, 2'd1, 6'd4, 36'h3);
    @(posedge clk);
    wait_done(400, cyc, who, err, rx, n1, m1, g1, nl);
    bus.i_req[0] = 1'b0;
    slv_respond = 1'b1;
    n_tests++; if (cyc !== 261) begin n_fail++; $display("FAIL timeout_cycle got=%0d exp=261", cyc); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_error got=%b exp=1", err); end
    n_tests++; if (rx !== 16'hC3C3) begin n_fail++; $display("FAIL timeout_rx_kept got=%h exp=c3c3", rx); end
    @(negedge clk);
    n_tests++; if (bus.o_nss !== 3'b111) begin n_fail++; $display("FAIL timeout_nss got=%b exp=111", bus.o_nss); end
  endtask

  task automatic test_bad_request();
    int cyc; logic [1:0] who, g1; logic err, m1; logic [15:0] rx; logic [2:0] n1; bit nl;
    logic [1:0] slv_t[3];
    logic [5:0] len_t[3];
    slv_t = '{2'd3, 2'd0, 2'd0};
    len_t = '{6'd36, 6'd0, 6'd37};
    for (int t = 0; t < 3; t++) begin
      set_req(0, slv_t[t], len_t[t], 36'hF);
      @(posedge clk);
      wait_done(10, cyc, who, err, rx, n1, m1, g1, nl);
      bus.i_req[0] = 1'b0;
      n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL bad_%0d_cycle got=%0d exp=1", t, cyc); end
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_%0d_error got=%b exp=1", t, err); end
      n_tests++; if (nl !== 1'b0) begin n_fail++; $display("FAIL bad_%0d_nss_activity got=%b exp=0", t, nl); end
      n_tests++; if (rx !== 16'hC3C3) begin n_fail++; $display("FAIL bad_%0d_rx_kept got=%h exp=c3c3", t, rx); end
      @(negedge clk);
      n_tests++; if (bus.o_nss !== 3'b111) begin n_fail++; $display("FAIL bad_%0d_nss_after got=%b exp=111", t, bus.o_nss); end
    end
  endtask

  task automatic test_reset_mid_shift_in();
    int cyc; logic [1:0] who, g1; logic err, m1; logic [15:0] rx; logic [2:0] n1; bit nl;
    slv_respond = 1'b1; slv_busy = 0; slv_delay = 2; slv_len = 4; slv_resp = 16'h5A5A;
    set_req(0, 2'd0, 6'd4, 36'hC);
    @(posedge clk);
    repeat (12) @(negedge clk);
    n_tests++; if (bus.o_grant !== 2'b01 || bus.o_nss !== 3'b110) begin n_fail++; $display("FAIL rst_pre got=%b/%b exp=01/110", bus.o_grant, bus.o_nss); end
    rst_n = 1'b0;
    bus.i_req = '0;
    #1;
    n_tests++; if (bus.o_nss !== 3'b111) begin n_fail++; $display("FAIL rst_nss got=%b exp=111", bus.o_nss); end
    n_tests++; if (bus.o_mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi got=%b exp=0", bus.o_mosi); end
    n_tests++; if (bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant got=%b exp=00", bus.o_grant); end
    n_tests++; if (bus.o_rx_data !== 16'h0000) begin n_fail++; $display("FAIL rst_rx got=%h exp=0000", bus.o_rx_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    slv_resp = 16'hBEEF;
    set_req(0, 2'd0, 6'd4, 36'h5);
    @(posedge clk);
    wait_done(100, cyc, who, err, rx, n1, m1, g1, nl);
    bus.i_req[0] = 1'b0;
    n_tests++; if (cyc !== 25) begin n_fail++; $display("FAIL rst_after_cycle got=%0d exp=25", cyc); end
    n_tests++; if (rx !== 16'hBEEF || err !== 1'b0) begin n_fail++; $display("FAIL rst_after_result got=%h/%b exp=beef/0", rx, err); end
    n_tests++; if (cap[3:0] !== 4'h5) begin n_fail++; $display("FAIL rst_after_mosi got=%h exp=5", cap[3:0]); end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_alu();
    test_busy_bus();
    test_contention();
    test_timeout();
    test_bad_request();
    test_reset_mid_shift_in();
    n_tests++; if (grant_multi !== 0) begin n_fail++; $display("FAIL grant_onehot got=%0d exp=0 multi-grant cycles", grant_multi); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=no_finish exp=finish");
    $fatal(1, "bench time limit");
  end

endmodule
